uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Byte buffer between the UART receiver's AXI-stream output and the USB CDC IN-endpoint stream in the USB-to-UART bridge. The UART receiver cannot be back-pressured by the host, so this block:
- absorbs line-rate bursts while USB IN transfers are pending;
- drives a hysteretic RTS flow-control output toward the remote UART;
- discards and counts bytes that arrive while the buffer is full.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of both streams
- DEPTH_LOG2, 6, log2 of storage depth (DEPTH = 64 entries)
- RTS_HIGH, 48, level at or above which rts_n deasserts (goes 1)
- RTS_LOW, 16, level at or below which rts_n reasserts (goes 0); RTS_LOW < RTS_HIGH <= DEPTH

Ports:
- clk  in  1  system clock (48 MHz in the bridge); single clock domain
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  byte from UART receiver
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  0 while rst is high, 1 otherwise (never stalls the receiver)
- m_axis_tdata  out  DATA_WIDTH  byte toward USB CDC in_data_i
- m_axis_tvalid  out  1  buffer non-empty
- m_axis_tready  in  1  USB CDC in_ready_o
- rts_n  out  1  0 = remote may send, 1 = remote must pause
- level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
- overflow_count  out  8  saturating count of discarded bytes
- overflow_clear  in  1  single-cycle pulse; clears overflow_count

## Operation
- Storage: DEPTH-entry memory with DEPTH_LOG2-bit write and read pointers.
  - Pointers wrap modulo DEPTH.
  - level is a separate counter, not derived from the pointers.
  - full = (level == DEPTH); empty = (level == 0).
- Push: s_axis_tvalid && s_axis_tready && (!full || pop).
  - Writes mem[wr_ptr] and increments wr_ptr.
- Pop: m_axis_tvalid && m_axis_tready.
  - Increments rd_ptr.
- Level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including when full and when level == 1.
- Drop: s_axis_tvalid && s_axis_tready && full && !pop.
  - Byte is discarded; memory and pointers are untouched.
  - overflow_count increments, saturating at 255.
- Counter clear:
  - overflow_clear alone sets overflow_count to 0.
  - overflow_clear and a drop in the same cycle set overflow_count to 1.
- Output stream is first-word-fall-through.
  - m_axis_tdata = mem[rd_ptr] whenever m_axis_tvalid = 1.
  - m_axis_tdata is don't-care when empty.
  - m_axis_tdata and m_axis_tvalid hold stable while m_axis_tvalid && !m_axis_tready.
- RTS is a two-state register, updated on the registered (post-update) level:
  - CLEAR (rts_n = 0) -> PAUSE (rts_n = 1) when level >= RTS_HIGH.
  - PAUSE -> CLEAR when level <= RTS_LOW.
  - Otherwise the state holds.
- Reset: pointers, level, overflow_count and rts_n clear to 0. Reset mid-stream discards all contents; no byte is emitted after reset.

## Timing
- Reset values (during and in the cycle after rst):
  - s_axis_tready = 0 during rst, 1 from the first cycle after rst is released.
  - m_axis_tvalid = 0, level = 0, overflow_count = 0, rts_n = 0.
- Push-to-output latency:
  - A byte pushed at edge N into an empty buffer gives m_axis_tvalid = 1 and valid m_axis_tdata after edge N (one cycle).
  - The write-side combinational path does not reach m_axis_tvalid.
- level, overflow_count and m_axis_tvalid are registered and update at the edge that commits the push, pop or drop.
- rts_n changes one cycle after level crosses a threshold. Examples:
  - level reaches 48 at edge N gives rts_n = 1 after edge N+1.
  - level falls to 16 at edge M gives rts_n = 0 after edge M+1.
- Throughput: one push and one pop per cycle sustained, with no bubbles.
- No combinational path from m_axis_tready to s_axis_tready. The drop decision may use the same-cycle pop.

## Test plan
- Reset then single byte:
  - Stimulus: push 0xA5 with m_axis_tready = 0.
  - Required: m_axis_tvalid = 1 one cycle later, tdata = 0xA5, level = 1.
  - Then raise tready: one pop, level = 0, tvalid = 0.
- Order and wrap:
  - Stimulus: push bytes 0x00..0x9F while popping at random 50% tready, 160 bytes total (crosses the pointer wrap twice).
  - Required: output exactly 0x00..0x9F in order, no duplicates or drops, overflow_count = 0.
- Full and drop:
  - Stimulus: tready = 0; push 70 bytes 0x10..0x55.
  - Required: level = 64, overflow_count = 6.
  - Then pop all: required output 0x10..0x4F.
  - Then pulse overflow_clear: required overflow_count = 0.
- Full with simultaneous push and pop:
  - Stimulus: at level 64, hold tvalid and tready for 10 cycles.
  - Required: level stays 64, overflow_count unchanged, output in order with no loss.
- RTS hysteresis:
  - Stimulus: fill to 47.
  - Required: rts_n = 0.
  - Stimulus: push to 48.
  - Required: rts_n = 1 next cycle.
  - Stimulus: drain to 17.
  - Required: rts_n still 1.
  - Stimulus: drain to 16.
  - Required: rts_n = 0 next cycle.
- Reset mid-operation and saturation:
  - Stimulus: at level 30, assert rst for 1 cycle.
  - Required: level = 0, tvalid = 0, rts_n = 0.
  - Stimulus: 300 drops while full.
  - Required: overflow_count = 255.
  - Stimulus: overflow_clear coincident with a drop.
  - Required: overflow_count = 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Byte buffer between the UART receiver stream and the USB CDC IN stream.
//   The receiver cannot be stalled, so bytes arriving while the buffer is full
//   are discarded and counted. A hysteretic RTS output asks the remote UART to
//   pause before the buffer fills.
//
// Ports
//   clk            system clock, single domain
//   rst            synchronous active-high reset
//   s_axis_tdata   byte from UART receiver
//   s_axis_tvalid  byte valid
//   s_axis_tready  0 while rst is high, 1 otherwise
//   m_axis_tdata   head byte (first-word-fall-through)
//   m_axis_tvalid  buffer non-empty (registered)
//   m_axis_tready  downstream ready
//   rts_n          0 = remote may send, 1 = remote must pause
//   level          occupancy 0..DEPTH
//   overflow_count saturating count of discarded bytes
//   overflow_clear single-cycle pulse clearing overflow_count
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 6,
    parameter int RTS_HIGH   = 48,
    parameter int RTS_LOW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  rts_n,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            overflow_count,
    input  logic                  overflow_clear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] HIGH_LEVEL = (DEPTH_LOG2 + 1)'(RTS_HIGH);
    localparam logic [DEPTH_LOG2:0] LOW_LEVEL  = (DEPTH_LOG2 + 1)'(RTS_LOW);

    localparam logic [0:0] RTS_CLEAR = 1'b0;
    localparam logic [0:0] RTS_PAUSE = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  valid_q, valid_d;
    logic [7:0]            ovf_q, ovf_d;
    logic [0:0]            rts_q, rts_d;

    logic full;
    logic push;
    logic pop;
    logic drop;

    // Ready depends only on reset, never on the read side.
    assign s_axis_tready = !rst;

    assign full = (level_q == FULL_LEVEL);
    assign pop  = valid_q && m_axis_tready;
    // A same-cycle pop frees the slot, so a full buffer can still accept.
    assign push = s_axis_tvalid && s_axis_tready && (!full || pop);
    assign drop = s_axis_tvalid && s_axis_tready && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        // A clear that coincides with a drop still records that drop.
        if (overflow_clear) begin
            ovf_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end

        valid_d = (level_d != '0);
    end

    // Hysteresis evaluated on the registered level, giving one cycle of lag.
    always_comb begin
        rts_d = rts_q;
        case (rts_q)
            RTS_CLEAR: if (level_q >= HIGH_LEVEL) rts_d = RTS_PAUSE;
            RTS_PAUSE: if (level_q <= LOW_LEVEL)  rts_d = RTS_CLEAR;
            default:   rts_d = RTS_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 8'd0;
            rts_q    <= RTS_CLEAR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            rts_q    <= rts_d;
        end
    end

    // Storage is not reset; contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_axis_tdata;
        end
    end

    assign m_axis_tdata   = mem[rd_ptr_q];
    assign m_axis_tvalid  = valid_q;
    assign level          = level_q;
    assign overflow_count = ovf_q;
    assign rts_n          = (rts_q == RTS_PAUSE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       rts_n;
    logic [6:0] level;
    logic [7:0] overflow_count;
    logic       overflow_clear;

    int         compared;
    int         mismatched;
    int         pops;
    logic       chk_pops;
    logic [7:0] exp_rd;
    int         sent;

    uart_rx_fifo #(
        .DATA_WIDTH(8),
        .DEPTH_LOG2(6),
        .RTS_HIGH  (48),
        .RTS_LOW   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rts_n         (rts_n),
        .level         (level),
        .overflow_count(overflow_count),
        .overflow_clear(overflow_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks any pop that the coming edge will commit, then advances one cycle.
    task automatic tick();
        if (chk_pops && m_axis_tvalid && m_axis_tready) begin
            chk("pop_data", {24'd0, m_axis_tdata}, {24'd0, exp_rd});
            exp_rd = exp_rd + 8'd1;
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = first + 8'(i);
            tick();
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        pops           = 0;
        chk_pops       = 1'b0;
        exp_rd         = 8'd0;
        sent           = 0;
        rst            = 1'b1;
        s_axis_tdata   = 8'd0;
        s_axis_tvalid  = 1'b0;
        m_axis_tready  = 1'b0;
        overflow_clear = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_level", {25'd0, level}, 32'd0);
        chk("rst_ovf", {24'd0, overflow_count}, 32'd0);
        chk("rst_rts", {31'd0, rts_n}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
        chk("post_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("post_rst_level", {25'd0, level}, 32'd0);

        // Single byte, one-cycle latency
        push_n(1, 8'hA5);
        chk("single_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("single_tdata", {24'd0, m_axis_tdata}, 32'hA5);
        chk("single_level", {25'd0, level}, 32'd1);
        chk_pops      = 1'b1;
        exp_rd        = 8'hA5;
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        chk("single_pops", pops, 32'd1);
        chk("single_empty_level", {25'd0, level}, 32'd0);
        chk("single_empty_tvalid", {31'd0, m_axis_tvalid}, 32'd0);

        // Order and pointer wrap with random back-pressure
        pops   = 0;
        exp_rd = 8'h00;
        sent   = 0;
        for (int c = 0; c < 2000 && (sent < 160 || m_axis_tvalid); c++) begin
            s_axis_tvalid = (sent < 160) && ($urandom_range(0, 1) == 1);
            s_axis_tdata  = sent[7:0];
            m_axis_tready = (sent >= 160) || (level >= 7'd60) || ($urandom_range(0, 1) == 1);
            tick();
            if (s_axis_tvalid) sent++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        chk("wrap_pops", pops, 32'd160);
        chk("wrap_level", {25'd0, level}, 32'd0);
        chk("wrap_ovf", {24'd0, overflow_count}, 32'd0);

        // Fill past full: 64 kept, 6 dropped
        push_n(70, 8'h10);
        chk("full_level", {25'd0, level}, 32'd64);
        chk("full_ovf", {24'd0, overflow_count}, 32'd6);
        pops          = 0;
        exp_rd        = 8'h10;
        m_axis_tready = 1'b1;
        repeat (70) tick();
        m_axis_tready = 1'b0;
        chk("full_drain_pops", pops, 32'd64);
        chk("full_drain_level", {25'd0, level}, 32'd0);
        chk("full_drain_ovf", {24'd0, overflow_count}, 32'd6);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("ovf_clear", {24'd0, overflow_count}, 32'd0);

        // Full with simultaneous push and pop
        push_n(64, 8'h80);
        chk("fullpp_pre_level", {25'd0, level}, 32'd64);
        pops          = 0;
        exp_rd        = 8'h80;
        m_axis_tready = 1'b1;
        push_n(10, 8'hC0);
        chk("fullpp_level", {25'd0, level}, 32'd64);
        chk("fullpp_ovf", {24'd0, overflow_count}, 32'd0);
        chk("fullpp_pops", pops, 32'd10);
        repeat (70) tick();
        m_axis_tready = 1'b0;
        chk("fullpp_drain_pops", pops, 32'd74);
        chk("fullpp_drain_level", {25'd0, level}, 32'd0);
        chk_pops = 1'b0;

        // RTS hysteresis
        push_n(47, 8'h00);
        chk("rts47_level", {25'd0, level}, 32'd47);
        chk("rts47", {31'd0, rts_n}, 32'd0);
        tick();
        chk("rts47_hold", {31'd0, rts_n}, 32'd0);
        push_n(1, 8'h2F);
        chk("rts48_level", {25'd0, level}, 32'd48);
        chk("rts48_lag", {31'd0, rts_n}, 32'd0);
        tick();
        chk("rts48", {31'd0, rts_n}, 32'd1);
        m_axis_tready = 1'b1;
        repeat (31) tick();
        m_axis_tready = 1'b0;
        chk("rts17_level", {25'd0, level}, 32'd17);
        tick();
        chk("rts17", {31'd0, rts_n}, 32'd1);
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        chk("rts16_level", {25'd0, level}, 32'd16);
        chk("rts16_lag", {31'd0, rts_n}, 32'd1);
        tick();
        chk("rts16", {31'd0, rts_n}, 32'd0);

        // Reset mid-operation
        push_n(14, 8'h40);
        chk("mid_level", {25'd0, level}, 32'd30);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", {25'd0, level}, 32'd0);
        chk("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("mid_rst_tready", {31'd0, s_axis_tready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_post_level", {25'd0, level}, 32'd0);
        chk("mid_post_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("mid_post_rts", {31'd0, rts_n}, 32'd0);

        // Saturation: 64 stored, 300 dropped
        push_n(364, 8'h00);
        chk("sat_level", {25'd0, level}, 32'd64);
        chk("sat_ovf", {24'd0, overflow_count}, 32'd255);
        overflow_clear = 1'b1;
        s_axis_tvalid  = 1'b1;
        tick();
        overflow_clear = 1'b0;
        s_axis_tvalid  = 1'b0;
        chk("clear_with_drop", {24'd0, overflow_count}, 32'd1);
        chk("clear_with_drop_level", {25'd0, level}, 32'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
